// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the LC-3b pipeline hazard controller: FSM states, per-register
// load/clear control and the load-use comparison helper.
package pipe_hazard_ctrl_pkg;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_IWAIT = 2'd1,
    HZ_DWAIT = 2'd2
  } lc3b_hz_state;

  typedef struct packed {
    logic load;
    logic clear;
  } lc3b_pipe_ctl;

  localparam lc3b_pipe_ctl CtlHold  = '{load: 1'b0, clear: 1'b0};
  localparam lc3b_pipe_ctl CtlLoad  = '{load: 1'b1, clear: 1'b0};
  localparam lc3b_pipe_ctl CtlClear = '{load: 1'b0, clear: 1'b1};

  // A source only creates a hazard when the ID instruction actually reads it.
  function automatic logic src_hazard(input logic use_src, input lc3b_reg src,
                                      input lc3b_reg dest);
    return use_src & (src == dest);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake and pipeline-control bundle between the datapath (master) and the
// hazard controller (slave).
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic    imem_req;
  logic    imem_resp;
  logic    dmem_req;
  logic    dmem_resp;
  logic    ex_mem_read;
  lc3b_reg ex_dest;
  lc3b_reg id_src1;
  lc3b_reg id_src2;
  logic    id_use_src1;
  logic    id_use_src2;
  logic    mem_redirect;

  logic    pc_load;
  logic    if_id_load;
  logic    id_ex_load;
  logic    ex_mem_load;
  logic    mem_wb_load;
  logic    if_id_clear;
  logic    id_ex_clear;
  logic    ex_mem_clear;
  logic    mem_wb_clear;

  modport master (
    output imem_req, imem_resp, dmem_req, dmem_resp, ex_mem_read, ex_dest,
           id_src1, id_src2, id_use_src1, id_use_src2, mem_redirect,
    input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
           if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear
  );

  modport slave (
    input  imem_req, imem_resp, dmem_req, dmem_resp, ex_mem_read, ex_dest,
           id_src1, id_src2, id_use_src1, id_use_src2, mem_redirect,
    output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
           if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module pipe_hazard_ctrl_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the five-stage LC-3b pipeline: combinational register
// controls, a miss-tracking FSM with timeout detection, and perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_hazard_ctrl_if.slave    hz,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count,
  output logic                 mem_timeout
);

  localparam int unsigned WaitW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT - 1);

  logic istall, dstall, luse;

  assign istall = hz.imem_req & ~hz.imem_resp;
  assign dstall = hz.dmem_req & ~hz.dmem_resp;
  assign luse   = hz.ex_mem_read &
                  (src_hazard(hz.id_use_src1, hz.id_src1, hz.ex_dest) |
                   src_hazard(hz.id_use_src2, hz.id_src2, hz.ex_dest));

  // ---------------------------------------------------------------------------
  // Pipeline register control (priority-ordered)
  // ---------------------------------------------------------------------------
  lc3b_pipe_ctl if_id_ctl, id_ex_ctl, ex_mem_ctl, mem_wb_ctl;
  logic         pc_load;
  logic         redirect_taken;

  always_comb begin
    pc_load        = 1'b0;
    redirect_taken = 1'b0;
    if_id_ctl      = CtlHold;
    id_ex_ctl      = CtlHold;
    ex_mem_ctl     = CtlHold;
    mem_wb_ctl     = CtlHold;

    if (reset) begin
      if_id_ctl  = CtlClear;
      id_ex_ctl  = CtlClear;
      ex_mem_ctl = CtlClear;
      mem_wb_ctl = CtlClear;
    end else if (dstall) begin
      // Whole pipe frozen; a pending redirect waits as well.
    end else if (istall) begin
      // PC must not move under an outstanding fetch, so a redirect is deferred
      // and the instruction leaving MEM is squashed instead of retired twice.
      id_ex_ctl  = CtlClear;
      mem_wb_ctl = hz.mem_redirect ? CtlClear : CtlLoad;
    end else if (hz.mem_redirect) begin
      pc_load        = 1'b1;
      redirect_taken = 1'b1;
      if_id_ctl      = CtlClear;
      id_ex_ctl      = CtlClear;
      ex_mem_ctl     = CtlClear;
      mem_wb_ctl     = CtlLoad;
    end else if (luse) begin
      id_ex_ctl  = CtlClear;
      ex_mem_ctl = CtlLoad;
      mem_wb_ctl = CtlLoad;
    end else begin
      pc_load    = 1'b1;
      if_id_ctl  = CtlLoad;
      id_ex_ctl  = CtlLoad;
      ex_mem_ctl = CtlLoad;
      mem_wb_ctl = CtlLoad;
    end
  end

  assign hz.pc_load      = pc_load;
  assign hz.if_id_load   = if_id_ctl.load;
  assign hz.id_ex_load   = id_ex_ctl.load;
  assign hz.ex_mem_load  = ex_mem_ctl.load;
  assign hz.mem_wb_load  = mem_wb_ctl.load;
  assign hz.if_id_clear  = if_id_ctl.clear;
  assign hz.id_ex_clear  = id_ex_ctl.clear;
  assign hz.ex_mem_clear = ex_mem_ctl.clear;
  assign hz.mem_wb_clear = mem_wb_ctl.clear;

  // ---------------------------------------------------------------------------
  // Miss-tracking FSM and wait-cycle timeout
  // ---------------------------------------------------------------------------
  lc3b_hz_state     state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_timeout_q;
  logic             waiting;
  logic             timeout_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN: begin
        if (dstall) begin
          state_d = HZ_DWAIT;
        end else if (istall) begin
          state_d = HZ_IWAIT;
        end
      end
      HZ_IWAIT: begin
        if (dstall) begin
          state_d = HZ_DWAIT;
        end else if (!istall) begin
          state_d = HZ_RUN;
        end
      end
      HZ_DWAIT: begin
        if (!dstall) begin
          state_d = istall ? HZ_IWAIT : HZ_RUN;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  assign waiting = (state_q != HZ_RUN);

  // Counter restarts on any state change so each access is timed separately.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting && (wait_q != WaitMax)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  assign timeout_hit = waiting && (state_d == state_q) && (wait_d == WaitMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HZ_RUN;
      wait_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      mem_timeout_q <= mem_timeout_q | timeout_hit;
    end
  end

  assign mem_timeout = mem_timeout_q;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  pipe_hazard_ctrl_sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (~pc_load),
    .count_o (stall_cycles)
  );

  pipe_hazard_ctrl_sat_counter #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (redirect_taken),
    .count_o (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each driven cycle pushes its expected
// controls and counter values; a negedge checker pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CntW = 4;
  localparam int unsigned Tmo  = 8;

  // {pc, if_id_l, id_ex_l, ex_mem_l, mem_wb_l, if_id_c, id_ex_c, ex_mem_c, mem_wb_c}
  localparam logic [8:0] C_RESET    = 9'b0_0000_1111;
  localparam logic [8:0] C_RUN      = 9'b1_1111_0000;
  localparam logic [8:0] C_FREEZE   = 9'b0_0000_0000;
  localparam logic [8:0] C_ISTALL   = 9'b0_0001_0100;
  localparam logic [8:0] C_ISTALL_RD = 9'b0_0000_0101;
  localparam logic [8:0] C_REDIR    = 9'b1_0001_1110;
  localparam logic [8:0] C_LUSE     = 9'b0_0011_0100;

  typedef struct packed {
    logic [8:0]      ctl;
    logic [CntW-1:0] stall;
    logic [CntW-1:0] flush;
    logic            tmo;
    logic            chk;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CntW-1:0] stall_cycles;
  logic [CntW-1:0] flush_count;
  logic            mem_timeout;
  logic [8:0]      obs_ctl;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t            sb_q[$];
  string           tag_q[$];
  exp_t            e;
  string           t;
  logic [CntW-1:0] m_stall = '0;
  logic [CntW-1:0] m_flush = '0;
  logic            m_tmo   = 1'b0;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .CNT_W   (CntW),
    .TIMEOUT (Tmo)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hz           (bus),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .mem_timeout  (mem_timeout)
  );

  always #5 clk = ~clk;

  assign obs_ctl = {bus.pc_load, bus.if_id_load, bus.id_ex_load, bus.ex_mem_load,
                    bus.mem_wb_load, bus.if_id_clear, bus.id_ex_clear, bus.ex_mem_clear,
                    bus.mem_wb_clear};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check_eq({t, ".ctl"}, 32'(obs_ctl), 32'(e.ctl));
      if (e.chk) begin
        check_eq({t, ".stall"}, 32'(stall_cycles), 32'(e.stall));
        check_eq({t, ".flush"}, 32'(flush_count), 32'(e.flush));
        check_eq({t, ".tmo"}, 32'(mem_timeout), 32'(e.tmo));
      end
    end
  end

  task automatic cyc(input string tag, input logic rst, input logic ireq, input logic iresp,
                     input logic dreq, input logic dresp, input logic redir, input logic rd,
                     input logic [2:0] dest, input logic [2:0] s1, input logic u1,
                     input logic [2:0] s2, input logic u2, input logic [8:0] ectl,
                     input logic chk);
    @(posedge clk);
    #1;
    reset            = rst;
    bus.imem_req     = ireq;
    bus.imem_resp    = iresp;
    bus.dmem_req     = dreq;
    bus.dmem_resp    = dresp;
    bus.mem_redirect = redir;
    bus.ex_mem_read  = rd;
    bus.ex_dest      = dest;
    bus.id_src1      = s1;
    bus.id_use_src1  = u1;
    bus.id_src2      = s2;
    bus.id_use_src2  = u2;
    // Counter outputs are registered: they show the totals from earlier cycles.
    sb_q.push_back('{ctl: ectl, stall: m_stall, flush: m_flush, tmo: m_tmo, chk: chk});
    tag_q.push_back(tag);
    if (rst) begin
      m_stall = '0;
      m_flush = '0;
      m_tmo   = 1'b0;
    end else begin
      if (!ectl[8] && (m_stall != '1)) m_stall = m_stall + 1'b1;
      if ((ectl == C_REDIR) && (m_flush != '1)) m_flush = m_flush + 1'b1;
    end
  endtask

  task automatic mem_cyc(input string tag, input logic ireq, input logic iresp,
                         input logic dreq, input logic dresp, input logic redir,
                         input logic [8:0] ectl);
    cyc(tag, 1'b0, ireq, iresp, dreq, dresp, redir, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0,
        ectl, 1'b1);
  endtask

  task automatic haz_cyc(input string tag, input logic rd, input logic [2:0] dest,
                         input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                         input logic u2, input logic redir, input logic [8:0] ectl);
    cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, redir, rd, dest, s1, u1, s2, u2, ectl, 1'b1);
  endtask

  task automatic rst_cyc(input string tag, input logic ireq, input logic chk);
    cyc(tag, 1'b1, ireq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
        3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), C_RESET, chk);
  endtask

  initial begin
    bus.imem_req     = 1'b0;
    bus.imem_resp    = 1'b0;
    bus.dmem_req     = 1'b0;
    bus.dmem_resp    = 1'b0;
    bus.mem_redirect = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_dest      = 3'd0;
    bus.id_src1      = 3'd0;
    bus.id_use_src1  = 1'b0;
    bus.id_src2      = 3'd0;
    bus.id_use_src2  = 1'b0;

    // Reset with random inputs; counters are unknown until the first reset edge.
    rst_cyc("rst0", 1'($urandom_range(0, 1)), 1'b0);
    rst_cyc("rst1", 1'($urandom_range(0, 1)), 1'b1);
    mem_cyc("run0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    mem_cyc("run1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);

    // Load-use detection on either source, gated by use flags and load type.
    haz_cyc("luse_s2",    1'b1, 3'd3, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0, C_LUSE);
    haz_cyc("after_luse", 1'b0, 3'd3, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0, C_RUN);
    haz_cyc("luse_nouse", 1'b1, 3'd3, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0, C_RUN);
    haz_cyc("luse_s1",    1'b1, 3'd5, 3'd5, 1'b1, 3'd2, 1'b1, 1'b0, C_LUSE);
    haz_cyc("no_load",    1'b0, 3'd5, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, C_RUN);

    // Data miss freezes everything, including a pending redirect.
    for (int i = 0; i < 4; i++) begin
      mem_cyc("dstall", 1'b0, 1'b0, 1'b1, 1'b0, (i == 2), C_FREEZE);
    end
    mem_cyc("dresp", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_RUN);

    // Fetch miss: plain bubble, then redirect deferred until fetch completes.
    mem_cyc("istall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_ISTALL);
    for (int i = 0; i < 3; i++) begin
      mem_cyc("istall_rd", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_ISTALL_RD);
    end
    mem_cyc("iresp_rd", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, C_REDIR);
    mem_cyc("post_rd",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);

    // Redirect beats load-use.
    haz_cyc("rd_luse",  1'b1, 3'd4, 3'd4, 1'b1, 3'd0, 1'b0, 1'b1, C_REDIR);
    haz_cyc("post_rl",  1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, C_RUN);

    // Both responses together, and responses without requests.
    mem_cyc("both_resp",   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, C_RUN);
    mem_cyc("orphan_resp", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_RUN);

    // Fetch held without response: flag appears from the 9th stalled cycle on.
    for (int i = 1; i <= 10; i++) begin
      if (i == 9) m_tmo = 1'b1;
      mem_cyc("iwait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_ISTALL);
    end
    mem_cyc("tmo_hold0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    mem_cyc("tmo_hold1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    rst_cyc("rst2", 1'b0, 1'b1);
    rst_cyc("rst3", 1'b0, 1'b1);

    // Reset mid-miss restarts the wait count, so 5 + 5 cycles never time out.
    for (int i = 0; i < 5; i++) mem_cyc("miss_a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_ISTALL);
    rst_cyc("rst_mid", 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) mem_cyc("miss_b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_ISTALL);
    mem_cyc("miss_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);

    // Saturation of both counters.
    for (int i = 0; i < 18; i++) begin
      haz_cyc("luse_sat", 1'b1, 3'd1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, C_LUSE);
    end
    for (int i = 0; i < 18; i++) begin
      mem_cyc("redir_sat", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_REDIR);
    end
    mem_cyc("sat_end0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    mem_cyc("sat_end1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);

    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
